vl_bitstream_unpacker: RTL

Parametrised LSB-first bit-stream unpacker for variable-length decoding. Accepts fixed-width words through a valid/ready handshake and presents a window of the oldest unconsumed bits. The consumer removes 0..WIDTH_OUT bits per cycle. Adds over-pop clamping, stream-position tracking, boundary alignment and flush. It sits between a word-oriented FIFO and a Huffman/Golomb symbol decoder.

---
 rtl/vl_pkg.sv | 34 +++
 rtl/vl_shift_insert.sv | 60 ++++++
 rtl/vl_bitstream_unpacker.sv | 87 ++++++++
 3 files changed

// File: rtl/vl_pkg.sv
// Shared helpers, types and step-ordering constants for the variable-length
// bit-stream unpacker and its downstream symbol decoder.
package vl_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned lvl_w(input int unsigned buffer_width);
    return clog2(buffer_width + 1);
  endfunction

  function automatic int unsigned pop_w(input int unsigned width_out);
    return clog2(width_out + 1);
  endfunction

  // A single-bit position register is kept even when ALIGN is 1.
  function automatic int unsigned pos_w(input int unsigned align);
    return (clog2(align) > 0) ? clog2(align) : 1;
  endfunction

  localparam int unsigned DEF_LVL_W = lvl_w(32);
  typedef logic [DEF_LVL_W-1:0] level_t;

  typedef enum logic [1:0] {
    STEP_POP   = 2'd0,
    STEP_ALIGN = 2'd1,
    STEP_PUSH  = 2'd2
  } step_e;

endpackage

// File: rtl/vl_shift_insert.sv
// Combinational next-state datapath: clamped pop, alignment skip, then
// OR-insert of the accepted word above the remaining bits.
module vl_shift_insert import vl_pkg::*; #(
  parameter int unsigned WIDTH_IN     = 8,
  parameter int unsigned WIDTH_OUT    = 16,
  parameter int unsigned BUFFER_WIDTH = 32,
  parameter int unsigned ALIGN        = 8,
  localparam int unsigned LVL_W       = lvl_w(BUFFER_WIDTH),
  localparam int unsigned POP_W       = pop_w(WIDTH_OUT),
  localparam int unsigned POS_W       = pos_w(ALIGN)
) (
  input  logic [BUFFER_WIDTH-1:0] buffer_i,
  input  logic [LVL_W-1:0]        level_i,
  input  logic [POS_W-1:0]        pos_i,
  input  logic [POP_W-1:0]        pop_len_i,
  input  logic                    align_i,
  input  logic                    push_i,
  input  logic [WIDTH_IN-1:0]     data_i,
  output logic [BUFFER_WIDTH-1:0] buffer_o,
  output logic [LVL_W-1:0]        level_o,
  output logic [POS_W-1:0]        pos_o
`ifdef VLU_ERR_EN
  ,
  output logic                    over_o
`endif
);

  localparam int unsigned AMASK = ALIGN - 1;

  logic [31:0] req, lvl0, eff_pop, lvl1, pos1, skip_raw, skip, lvl2, pos2;
  logic [BUFFER_WIDTH-1:0] sh1, sh2, ins;

  always_comb begin
    req  = 32'(pop_len_i);
    lvl0 = 32'(level_i);
    eff_pop = (req > WIDTH_OUT) ? WIDTH_OUT : req;
    if (eff_pop > lvl0) eff_pop = lvl0;
    sh1  = buffer_i >> eff_pop;
    lvl1 = lvl0 - eff_pop;
    pos1 = (32'(pos_i) + eff_pop) & AMASK;

    skip_raw = align_i ? ((ALIGN - pos1) & AMASK) : '0;
    skip     = (skip_raw > lvl1) ? lvl1 : skip_raw;
    sh2  = sh1 >> skip;
    lvl2 = lvl1 - skip;
    pos2 = (pos1 + skip) & AMASK;

    // Bits above the level are always zero, so OR is a safe insert.
    ins = '0;
    if (push_i) ins = BUFFER_WIDTH'(data_i) << lvl2;
    buffer_o = sh2 | ins;
    level_o  = LVL_W'(push_i ? (lvl2 + WIDTH_IN) : lvl2);
    pos_o    = POS_W'(pos2);
  end

`ifdef VLU_ERR_EN
  assign over_o = (req > lvl0) || (skip_raw > lvl1);
`endif

endmodule

// File: rtl/vl_bitstream_unpacker.sv
// LSB-first bit-stream unpacker with clamped pop, alignment and flush.
// Define VLU_ERR_EN to build the sticky over-pop err flag; otherwise err is 0.
module vl_bitstream_unpacker import vl_pkg::*; #(
  parameter int unsigned WIDTH_IN     = 8,
  parameter int unsigned WIDTH_OUT    = 16,
  parameter int unsigned BUFFER_WIDTH = 32,
  parameter int unsigned ALIGN        = 8,
  localparam int unsigned LVL_W       = lvl_w(BUFFER_WIDTH),
  localparam int unsigned POP_W       = pop_w(WIDTH_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic [WIDTH_OUT-1:0] q,
  output logic [LVL_W-1:0]     q_level,
  input  logic [POP_W-1:0]     pop_len,
  input  logic                 align,
  input  logic                 flush,
  output logic                 err
);

  localparam int unsigned POS_W = pos_w(ALIGN);

  logic [BUFFER_WIDTH-1:0] buffer_q, buffer_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    push;

  assign in_ready = !flush && (32'(level_q) <= (BUFFER_WIDTH - WIDTH_IN));
  assign push     = in_valid && in_ready;

`ifdef VLU_ERR_EN
  logic over;
  logic err_q;
`endif

  vl_shift_insert #(
    .WIDTH_IN     (WIDTH_IN),
    .WIDTH_OUT    (WIDTH_OUT),
    .BUFFER_WIDTH (BUFFER_WIDTH),
    .ALIGN        (ALIGN)
  ) u_datapath (
    .buffer_i  (buffer_q),
    .level_i   (level_q),
    .pos_i     (pos_q),
    .pop_len_i (pop_len),
    .align_i   (align),
    .push_i    (push),
    .data_i    (in_data),
    .buffer_o  (buffer_d),
    .level_o   (level_d),
    .pos_o     (pos_d)
`ifdef VLU_ERR_EN
    ,
    .over_o    (over)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buffer_q <= '0;
      level_q  <= '0;
      pos_q    <= '0;
    end else begin
      buffer_q <= buffer_d;
      level_q  <= level_d;
      pos_q    <= pos_d;
    end
  end

  assign q       = buffer_q[WIDTH_OUT-1:0];
  assign q_level = level_q;

`ifdef VLU_ERR_EN
  // Flush clears the stream but leaves a recorded over-pop visible.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (!flush && over) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
